// File: rtl/matrix_frame_streamer.sv
// Snapshots the playfield on a frame request and streams the composed frame one row per
// valid/ready handshake, top row first, with ball clipping, blinking and done/drop status.
module matrix_frame_streamer #(
    parameter int ROWS         = 12,
    parameter int COLS         = 16,
    parameter int BRICK_ROWS   = 7,
    parameter int BRICK_W      = 2,
    parameter int PLATE_ROW    = 10,
    parameter int BLINK_FRAMES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_req,
    input  logic [BRICK_ROWS*(COLS/BRICK_W)-1:0] bricks,
    input  logic [COLS-1:0]               plate_row,
    input  logic [3:0]                    ball_row,
    input  logic [3:0]                    ball_col,
    input  logic                          blink_en,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [COLS-1:0]               row_data,
    output logic [$clog2(ROWS)-1:0]       row_idx,
    output logic                          row_last,
    output logic                          frame_done,
    output logic                          frame_dropped
);
    localparam int BPR   = COLS / BRICK_W;
    localparam int NB    = BRICK_ROWS * BPR;
    localparam int IDX_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state_reg, state_next;
    logic [NB-1:0]     bricks_reg, bricks_next;
    logic [COLS-1:0]   plate_reg, plate_next;
    logic [3:0]        ball_row_reg, ball_row_next;
    logic [3:0]        ball_col_reg, ball_col_next;
    logic              blink_en_reg, blink_en_next;
    logic              blink_phase_reg, blink_phase_next;
    logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
    logic              row_valid_reg, row_valid_next;
    logic [COLS-1:0]   row_data_reg, row_data_next;
    logic [IDX_W-1:0]  row_idx_reg, row_idx_next;
    logic              row_last_reg, row_last_next;
    logic              frame_done_reg, frame_done_next;
    logic              frame_dropped_reg, frame_dropped_next;

    // In IDLE the row being composed is row 0 of the frame about to be captured, so the
    // live inputs stand in for the snapshot that is loaded on the same edge.
    logic              capture;
    logic [NB-1:0]     src_bricks;
    logic [COLS-1:0]   src_plate;
    logic [3:0]        src_ball_row;
    logic [3:0]        src_ball_col;
    logic              src_blink;
    logic [IDX_W-1:0]  compose_idx;
    logic              ball_hit;
    logic              plate_en;
    logic [BPR-1:0]    brick_slice;
    logic [COLS-1:0]   compose_row;

    assign capture      = (state_reg == IDLE);
    assign src_bricks   = capture ? bricks    : bricks_reg;
    assign src_plate    = capture ? plate_row : plate_reg;
    assign src_ball_row = capture ? ball_row  : ball_row_reg;
    assign src_ball_col = capture ? ball_col  : ball_col_reg;
    assign src_blink    = capture ? blink_en  : blink_en_reg;
    assign compose_idx  = capture ? '0 : row_idx_reg + IDX_W'(1);

    assign plate_en = (int'(compose_idx) == PLATE_ROW);
    assign ball_hit = (!src_blink || !blink_phase_reg)
                    && (int'(src_ball_row) == int'(compose_idx))
                    && (int'(src_ball_row) < ROWS)
                    && (int'(src_ball_col) < COLS);

    always_comb begin
        brick_slice = '0;
        if (int'(compose_idx) < BRICK_ROWS)
            brick_slice = src_bricks[int'(compose_idx)*BPR +: BPR];
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_pixel
        assign compose_row[gi] = brick_slice[gi/BRICK_W]
                               | (plate_en & src_plate[gi])
                               | (ball_hit & (int'(src_ball_col) == gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            bricks_reg        <= '0;
            plate_reg         <= '0;
            ball_row_reg      <= '0;
            ball_col_reg      <= '0;
            blink_en_reg      <= 1'b0;
            blink_phase_reg   <= 1'b0;
            frame_cnt_reg     <= '0;
            row_valid_reg     <= 1'b0;
            row_data_reg      <= '0;
            row_idx_reg       <= '0;
            row_last_reg      <= 1'b0;
            frame_done_reg    <= 1'b0;
            frame_dropped_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            bricks_reg        <= bricks_next;
            plate_reg         <= plate_next;
            ball_row_reg      <= ball_row_next;
            ball_col_reg      <= ball_col_next;
            blink_en_reg      <= blink_en_next;
            blink_phase_reg   <= blink_phase_next;
            frame_cnt_reg     <= frame_cnt_next;
            row_valid_reg     <= row_valid_next;
            row_data_reg      <= row_data_next;
            row_idx_reg       <= row_idx_next;
            row_last_reg      <= row_last_next;
            frame_done_reg    <= frame_done_next;
            frame_dropped_reg <= frame_dropped_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        bricks_next        = bricks_reg;
        plate_next         = plate_reg;
        ball_row_next      = ball_row_reg;
        ball_col_next      = ball_col_reg;
        blink_en_next      = blink_en_reg;
        blink_phase_next   = blink_phase_reg;
        frame_cnt_next     = frame_cnt_reg;
        row_valid_next     = row_valid_reg;
        row_data_next      = row_data_reg;
        row_idx_next       = row_idx_reg;
        row_last_next      = row_last_reg;
        frame_done_next    = 1'b0;
        frame_dropped_next = frame_req && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (frame_req) begin
                    bricks_next    = bricks;
                    plate_next     = plate_row;
                    ball_row_next  = ball_row;
                    ball_col_next  = ball_col;
                    blink_en_next  = blink_en;
                    row_valid_next = 1'b1;
                    row_idx_next   = compose_idx;
                    row_data_next  = compose_row;
                    row_last_next  = (int'(compose_idx) == ROWS - 1);
                    state_next     = STREAM;
                end
            end
            STREAM: begin
                if (row_valid_reg && row_ready) begin
                    if (row_last_reg) begin
                        row_valid_next  = 1'b0;
                        row_last_next   = 1'b0;
                        frame_done_next = 1'b1;
                        state_next      = DONE;
                    end else begin
                        row_idx_next  = compose_idx;
                        row_data_next = compose_row;
                        row_last_next = (int'(compose_idx) == ROWS - 1);
                    end
                end
            end
            DONE: begin
                // Frame count advances on every completed frame, blinking or not.
                if (int'(frame_cnt_reg) == BLINK_FRAMES - 1) begin
                    frame_cnt_next   = '0;
                    blink_phase_next = !blink_phase_reg;
                end else begin
                    frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign row_valid     = row_valid_reg;
    assign row_data      = row_data_reg;
    assign row_idx       = row_idx_reg;
    assign row_last      = row_last_reg;
    assign frame_done    = frame_done_reg;
    assign frame_dropped = frame_dropped_reg;
endmodule
